// File: rtl/ialu_pkg.sv
// -----------------------------------------------------------------------------
// ialu_pkg
// Shared definitions for the pipelined integer ALU:
//   - opcode encodings
//   - operand/result width helpers (in_w, out_w)
//   - legal LATENCY range and its check
//   - opcode classifier used to turn NOP/reserved ops into bubbles
// -----------------------------------------------------------------------------
package ialu_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_MAC   = 3'b100;
  localparam logic [2:0] OP_ACCRD = 3'b101;

  localparam int LATENCY_MIN = 2;
  localparam int LATENCY_MAX = 16;

  // Operand width: full product plus guard bits, less the duplicated sign bit.
  function automatic int in_w(input int dwidth, input int guard);
    return 2 * dwidth + guard - 1;
  endfunction

  // Result width: one extra bit so ADD/SUB of two IN_W operands never overflows.
  function automatic int out_w(input int dwidth, input int guard);
    return in_w(dwidth, guard) + 1;
  endfunction

  function automatic bit latency_ok(input int latency);
    return (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX);
  endfunction

  // MUL..ACCRD are real operations; NOP and the reserved codes become bubbles.
  function automatic logic op_is_active(input logic [2:0] op);
    return (op >= OP_MUL) && (op <= OP_ACCRD);
  endfunction

endpackage

// File: rtl/ialu_delay_line.sv
// -----------------------------------------------------------------------------
// ialu_delay_line
// Enabled shift register that carries a valid bit and a payload through DEPTH
// stages. All stages advance together when en=1 and hold when en=0.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            advance enable
//   valid_i       valid bit entering stage 0
//   data_i        payload entering stage 0
//   valid_o       valid bit leaving the last stage
//   data_o        payload leaving the last stage
// -----------------------------------------------------------------------------
module ialu_delay_line
  import ialu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if ((DEPTH < LATENCY_MIN - 1) || (DEPTH > LATENCY_MAX - 1)) begin : g_bad_depth
    $error("ialu_delay_line: DEPTH out of range");
  end

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the value its predecessor held before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: the payload array is reset as well, not just the valid bits, so
      // Y never exposes stale operands after reset; it is only DEPTH flops deep.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (en) begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/ialu_pipe.sv
// -----------------------------------------------------------------------------
// ialu_pipe
// Pipelined integer ALU with a valid pipeline, global stall enable and an
// internal multiply-accumulate register (ACC) with read-and-clear.
// Operations enter a LATENCY-1 deep delay line; the final execute/output stage
// computes the result, updates ACC in program order and registers Y.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   en         pipeline advance enable; 0 freezes every register
//   in_valid   operation present on opcode/A/B
//   opcode     operation select (NOP, MUL, SUB, ADD, MAC, ACCRD)
//   A, B       IN_W-bit two's complement operands
//   Y          OUT_W-bit registered result
//   out_valid  Y holds a new result this cycle
//   ovf        signed overflow of the accumulator on this result (MAC only)
// -----------------------------------------------------------------------------
module ialu_pipe
  import ialu_pkg::*;
#(
  parameter  int DWIDTH  = 16,
  parameter  int GUARD   = 6,
  parameter  int LATENCY = 5,
  localparam int IN_W    = in_w(DWIDTH, GUARD),
  localparam int OUT_W   = out_w(DWIDTH, GUARD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [2:0]       opcode,
  input  logic [IN_W-1:0]  A,
  input  logic [IN_W-1:0]  B,
  output logic [OUT_W-1:0] Y,
  output logic             out_valid,
  output logic             ovf
);

  localparam int PW = 3 + 2 * IN_W;

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("ialu_pipe: LATENCY must be within 2..16");
  end
  if (GUARD < 1) begin : g_bad_guard
    $error("ialu_pipe: GUARD must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Operand transport: bubbles are marked invalid at entry so the execute
  // stage never sees NOP or reserved codes with valid set.
  // ---------------------------------------------------------------------------
  logic          in_op_valid;
  logic          ex_valid;
  logic [PW-1:0] ex_payload;
  logic [2:0]    ex_op;
  logic [IN_W-1:0] ex_a;
  logic [IN_W-1:0] ex_b;

  assign in_op_valid = in_valid && op_is_active(opcode);

  ialu_delay_line #(
    .DEPTH (LATENCY - 1),
    .WIDTH (PW)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .valid_i (in_op_valid),
    .data_i  ({opcode, A, B}),
    .valid_o (ex_valid),
    .data_o  (ex_payload)
  );

  assign ex_op = ex_payload[PW-1 -: 3];
  assign ex_a  = ex_payload[2*IN_W-1 -: IN_W];
  assign ex_b  = ex_payload[IN_W-1:0];

  // ---------------------------------------------------------------------------
  // Execute datapath
  // ---------------------------------------------------------------------------
  logic               out_valid_q, out_valid_d;
  logic               ovf_q, ovf_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic [OUT_W-1:0]   acc_q, acc_d;

  logic signed [2*DWIDTH-1:0] mul_a, mul_b, prod;
  logic [OUT_W-1:0]           prod_ext, sext_a, sext_b, mac_sum;
  logic                       mac_ovf;

  always_comb begin
    // Operands are widened to the product width first so the multiply is
    // computed at full precision without relying on context sizing.
    mul_a    = {{DWIDTH{ex_a[DWIDTH-1]}}, ex_a[DWIDTH-1:0]};
    mul_b    = {{DWIDTH{ex_b[DWIDTH-1]}}, ex_b[DWIDTH-1:0]};
    prod     = mul_a * mul_b;
    prod_ext = {{GUARD{prod[2*DWIDTH-1]}}, prod};
    sext_a   = {ex_a[IN_W-1], ex_a};
    sext_b   = {ex_b[IN_W-1], ex_b};
    mac_sum  = acc_q + prod_ext;
    // Overflow: addends agree in sign but the wrapped sum does not.
    mac_ovf  = (acc_q[OUT_W-1] == prod_ext[OUT_W-1]) &&
               (mac_sum[OUT_W-1] != acc_q[OUT_W-1]);
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    out_valid_d = ex_valid;
    y_d         = y_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (ex_valid) begin
      ovf_d = 1'b0;
      case (ex_op)
        OP_MUL: y_d = prod_ext;
        OP_SUB: y_d = sext_a - sext_b;
        OP_ADD: y_d = sext_a + sext_b;
        OP_MAC: begin
          y_d   = mac_sum;
          acc_d = mac_sum;
          ovf_d = mac_ovf;
        end
        OP_ACCRD: begin
          y_d   = acc_q;
          acc_d = '0;
        end
        default: y_d = y_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else if (en) begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ialu_pipe.sv
// -----------------------------------------------------------------------------
// tb_ialu_pipe
// Three ialu_pipe instances share clk/rst/en:
//   dut_a: default parameters (DWIDTH=16, GUARD=6, LATENCY=5)
//   dut_b: GUARD=1 so the accumulator can be driven into overflow quickly
//   dut_c: LATENCY=2, the shortest legal pipeline
// Expected results are produced by a behavioural model when an op is driven,
// queued with the enabled-edge count at which they must appear, and compared
// on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_ialu_pipe;
  import ialu_pkg::*;

  localparam int LAT_A = 5;
  localparam int LAT_B = 5;
  localparam int LAT_C = 2;
  localparam int OW_A  = 38;
  localparam int OW_B  = 33;
  localparam logic [63:0] MASK_A = (64'd1 << OW_A) - 64'd1;
  localparam logic [63:0] MASK_B = (64'd1 << OW_B) - 64'd1;

  logic clk = 1'b0;
  logic rst, en;

  logic        iv_a, iv_b, iv_c;
  logic [2:0]  op_a, op_b, op_c;
  logic [36:0] a_a, b_a, a_c, b_c;
  logic [31:0] a_b, b_b;
  logic [37:0] y_a, y_c;
  logic [32:0] y_b;
  logic        ov_a, ov_b, ov_c;
  logic        f_a, f_b, f_c;

  ialu_pipe #(.DWIDTH(16), .GUARD(6), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv_a), .opcode(op_a),
    .A(a_a), .B(b_a), .Y(y_a), .out_valid(ov_a), .ovf(f_a));

  ialu_pipe #(.DWIDTH(16), .GUARD(1), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv_b), .opcode(op_b),
    .A(a_b), .B(b_b), .Y(y_b), .out_valid(ov_b), .ovf(f_b));

  ialu_pipe #(.DWIDTH(16), .GUARD(6), .LATENCY(LAT_C)) dut_c (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv_c), .opcode(op_c),
    .A(a_c), .B(b_c), .Y(y_c), .out_valid(ov_c), .ovf(f_c));

  always #5 clk = ~clk;

  typedef struct {
    longint y;
    bit     ovf;
    int     due;
  } exp_t;

  exp_t   q_a[$], q_b[$], q_c[$];
  longint acc_a, acc_b, acc_c;
  bit     ev_a, ev_b, ev_c;
  longint ey_a, ey_b, ey_c;
  bit     eo_a, eo_b, eo_c;
  int     en_cnt;
  int     errors;
  int     checks;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wrap a value to ow bits, two's complement.
  function automatic longint wrapw(input longint x, input int ow);
    longint m;
    longint r;
    m = longint'(1) << ow;
    r = x & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  function automatic void model(input int ow, input logic [2:0] op, input longint a,
                                input longint b, inout longint acc,
                                output bit v, output longint y, output bit o);
    longint p;
    longint s;
    p = longint'($signed(a[15:0])) * longint'($signed(b[15:0]));
    v = 1'b1;
    o = 1'b0;
    y = 0;
    case (op)
      3'b001: y = p;
      3'b010: y = wrapw(a - b, ow);
      3'b011: y = wrapw(a + b, ow);
      3'b100: begin
        s   = wrapw(acc + p, ow);
        o   = ((acc < 0) == (p < 0)) && ((s < 0) != (acc < 0));
        acc = s;
        y   = s;
      end
      3'b101: begin
        y   = acc;
        acc = 0;
      end
      default: v = 1'b0;
    endcase
  endfunction

  // Drive one op to dut_a and dut_c; queue its expected result if accepted.
  task automatic issue_ac(input logic [2:0] op, input longint a, input longint b);
    bit     v, o;
    longint y;
    exp_t   e;
    iv_a = 1'b1; op_a = op; a_a = 37'(a); b_a = 37'(b);
    iv_c = 1'b1; op_c = op; a_c = 37'(a); b_c = 37'(b);
    if (en) begin
      model(OW_A, op, a, b, acc_a, v, y, o);
      if (v) begin e.y = y; e.ovf = o; e.due = en_cnt + LAT_A; q_a.push_back(e); end
      model(OW_A, op, a, b, acc_c, v, y, o);
      if (v) begin e.y = y; e.ovf = o; e.due = en_cnt + LAT_C; q_c.push_back(e); end
    end
  endtask

  task automatic issue_b(input logic [2:0] op, input longint a, input longint b);
    bit     v, o;
    longint y;
    exp_t   e;
    iv_b = 1'b1; op_b = op; a_b = 32'(a); b_b = 32'(b);
    if (en) begin
      model(OW_B, op, a, b, acc_b, v, y, o);
      if (v) begin e.y = y; e.ovf = o; e.due = en_cnt + LAT_B; q_b.push_back(e); end
    end
  endtask

  task automatic check_all();
    check("a.out_valid", 64'(ov_a), 64'(ev_a));
    check("a.Y",         {26'b0, y_a}, 64'(ey_a) & MASK_A);
    check("a.ovf",       64'(f_a), 64'(eo_a));
    check("b.out_valid", 64'(ov_b), 64'(ev_b));
    check("b.Y",         {31'b0, y_b}, 64'(ey_b) & MASK_B);
    check("b.ovf",       64'(f_b), 64'(eo_b));
    check("c.out_valid", 64'(ov_c), 64'(ev_c));
    check("c.Y",         {26'b0, y_c}, 64'(ey_c) & MASK_A);
    check("c.ovf",       64'(f_c), 64'(eo_c));
  endtask

  // One clock: advance the model on enabled edges, compare on the falling edge,
  // then drop in_valid so the next step starts idle.
  task automatic step();
    @(posedge clk);
    if (en) en_cnt++;
    @(negedge clk);
    if (en) begin
      ev_a = (q_a.size() > 0) && (q_a[0].due == en_cnt);
      if (ev_a) begin ey_a = q_a[0].y; eo_a = q_a[0].ovf; void'(q_a.pop_front()); end
      ev_b = (q_b.size() > 0) && (q_b[0].due == en_cnt);
      if (ev_b) begin ey_b = q_b[0].y; eo_b = q_b[0].ovf; void'(q_b.pop_front()); end
      ev_c = (q_c.size() > 0) && (q_c[0].due == en_cnt);
      if (ev_c) begin ey_c = q_c[0].y; eo_c = q_c[0].ovf; void'(q_c.pop_front()); end
    end
    check_all();
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
  endtask

  task automatic clear_model();
    q_a.delete(); q_b.delete(); q_c.delete();
    acc_a = 0; acc_b = 0; acc_c = 0;
    ev_a = 0; ev_b = 0; ev_c = 0;
    ey_a = 0; ey_b = 0; ey_c = 0;
    eo_a = 0; eo_b = 0; eo_c = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    clear_model();
    #1 check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    en_cnt = 0;
    rst = 1'b1;
    en  = 1'b1;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    op_a = OP_NOP; op_b = OP_NOP; op_c = OP_NOP;
    a_a = '0; b_a = '0; a_b = '0; b_b = '0; a_c = '0; b_c = '0;
    clear_model();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Signed multiply corners.
    issue_ac(OP_MUL, 'h7FFF, 'h8000); step();
    issue_ac(OP_MUL, -1, -1);         step();
    repeat (6) step();

    // ADD/SUB streaming, then bubbles that must not produce results.
    issue_ac(OP_ADD, 5, 7);              step();
    issue_ac(OP_SUB, 3, 10);             step();
    issue_ac(OP_ADD, 'h0FFFFFFFFF, 1);   step();
    issue_ac(OP_NOP, 9, 9);              step();
    issue_ac(3'b110, 9, 9);              step();
    issue_ac(3'b111, 9, 9);              step();
    repeat (6) step();

    // Stall mid-flight; ops offered while en=0 must be ignored.
    issue_ac(OP_ADD, 1, 1);  step();
    issue_ac(OP_SUB, 10, 3); step();
    issue_ac(OP_MUL, 2, 3);  step();
    step();
    en = 1'b0;
    repeat (4) begin
      issue_ac(OP_ADD, 100, 100);
      step();
    end
    en = 1'b1;
    repeat (8) step();

    // Accumulate, read-and-clear, accumulate from zero.
    issue_ac(OP_MAC, 3, 4);    step();
    issue_ac(OP_MAC, -2, 5);   step();
    issue_ac(OP_ACCRD, 0, 0);  step();
    issue_ac(OP_MAC, 1, 1);    step();
    repeat (6) step();

    // Drive the GUARD=1 accumulator past +max.
    repeat (6) begin
      issue_b(OP_MAC, 'h7FFF, 'h7FFF);
      step();
    end
    repeat (6) step();

    // Reset with ops in flight; nothing stale may emerge and ACC restarts at 0.
    issue_ac(OP_MAC, 3, 3); issue_b(OP_MAC, 7, 7); step();
    issue_ac(OP_ADD, 1, 2);  step();
    issue_ac(OP_MAC, 2, 2);  step();
    issue_ac(OP_SUB, 5, 1);  step();
    pulse_reset();
    repeat (6) step();
    issue_ac(OP_MAC, 1, 1); issue_b(OP_MAC, 1, 1); step();
    repeat (6) step();

    check("a.pending", 64'(q_a.size()), 64'd0);
    check("b.pending", 64'(q_b.size()), 64'd0);
    check("c.pending", 64'(q_c.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ialu_pipe.md
Name: ialu_pipe

Overview:
Parametrised, pipelined integer ALU for the FIR datapath. It generalises the fixed 5-stage behavioural IALU with configurable data width, guard bits and latency, and adds a valid pipeline, a global stall enable, subtract, and an internal multiply-accumulate register with read-and-clear. Results are strictly in order, one operation per enabled cycle.

Parameters:
DWIDTH, 16, multiplier operand width; signed products use A[DWIDTH-1:0] and B[DWIDTH-1:0].
GUARD, 6, accumulation guard bits; IN_W = 2*DWIDTH+GUARD-1, OUT_W = IN_W+1.
LATENCY, 5, total register stages from input sample to Y, including the output register; legal range 2..16.

Ports:
clk        input   1      rising-edge clock
rst        input   1      asynchronous reset, active-high
en         input   1      pipeline advance enable; 0 freezes every register
in_valid   input   1      operation present on opcode/A/B
opcode     input   3      operation select (see Behaviour)
A          input   IN_W   operand A, two's complement
B          input   IN_W   operand B, two's complement
Y          output  OUT_W  result, registered
out_valid  output  1      Y holds a new result this cycle
ovf        output  1      signed overflow of the accumulator on this result

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. While rst=1, all valid bits, Y, ovf and the accumulator ACC (OUT_W bits) are 0. Pipeline data registers also reset to 0.
- Opcodes: 000 NOP; 001 MUL; 010 SUB; 011 ADD; 100 MAC; 101 ACCRD (read-and-clear); 110/111 reserved, treated as NOP.
- Sampling: the operation is accepted on a rising edge with en=1 and in_valid=1. NOP and reserved opcodes enter as bubbles (valid=0).
- Latency: an operation accepted at edge k drives Y and out_valid=1 after edge k+LATENCY-1, counting only edges with en=1.
- out_valid is high for exactly one enabled cycle per accepted non-NOP op. When out_valid=0, Y holds its last value.
- en=0 stall: all stages, Y, out_valid, ovf and ACC hold. in_valid and the operands are ignored. No op is lost or duplicated across a stall.
- Arithmetic, all results in OUT_W bits, two's complement:
  - MUL: sign-extend( signed(A[DWIDTH-1:0]) * signed(B[DWIDTH-1:0]) ).
  - ADD: sext(A)+sext(B). SUB: sext(A)-sext(B). Neither can overflow at OUT_W.
- MAC: ACC_next = ACC + sext(product), wrapping modulo 2^OUT_W. Y = ACC_next. ovf=1 iff both addends have the same sign and the sum's sign differs from it.
- ACCRD: Y = current ACC, ACC becomes 0 on the same edge, ovf=0.
- ACC is updated only in the output stage, in program order. A MAC immediately following an ACCRD accumulates from 0.
- ovf is 0 for every op other than MAC. It updates only together with out_valid and holds otherwise.
- Reset mid-operation: all in-flight ops are discarded and ACC clears. The first accepted op after rst deasserts has full latency.
- Back-to-back MACs need no forwarding, because accumulation happens in a single stage.

Decomposition:
- Package ialu_pkg holds:
  - opcode localparams (OP_NOP, OP_MUL, OP_SUB, OP_ADD, OP_MAC, OP_ACCRD);
  - width functions in_w(DWIDTH,GUARD) and out_w(DWIDTH,GUARD);
  - the LATENCY range check.
- Sub-module ialu_delay_line carries {valid, opcode, A, B} through LATENCY-1 enabled stages.
  - Parameters: depth and payload width; it has clk, rst, en.
  - Valid resets to 0.
- The top level contains the execute/output stage and ACC.

Test Plan:
- DWIDTH=16, LATENCY=5: MUL A=0x7FFF, B=0x8000 at edge 0 -> out_valid after edge 4, Y=-0x3FFF8000 sign-extended to 38 bits, ovf=0; A=-1, B=-1 -> Y=1.
- ADD/SUB streaming with en=1: ADD 5+7, SUB 3-10, ADD 0x0FFFFFFFFF+1 on consecutive edges -> Y=12, -7, 0x1000000000 on consecutive cycles, in order.
- Stall: issue 3 ops, hold en=0 for 4 cycles mid-flight -> Y/out_valid frozen during the stall; results resume with no loss or duplication; total latency is stretched by exactly 4.
- MAC/ACCRD: MAC 3*4, MAC -2*5, ACCRD, MAC 1*1 -> Y=12, 2, 2 (ACC cleared), 1.
- Overflow: preload ACC near +max via repeated MAC 0x7FFF*0x7FFF (with a small GUARD override such as GUARD=1) -> ovf=1 exactly on the wrapping result, Y is the wrapped value.
- Reset mid-flight: 4 ops in flight, pulse rst asynchronously between edges -> out_valid, Y and ACC are 0 immediately; no stale results appear afterwards; a new op completes with LATENCY; repeat with LATENCY=2.
